change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
Coin-return controller at the far end of the vending payment path. The payment FSM signals that change is owed; this block accepts the change amount over a valid/ready request. It then pays the amount out coin by coin to the coin hopper, largest coin first, over a valid/ack handshake. It tracks per-denomination hopper inventory and reports completion, or shortfall if the hopper cannot cover the amount.

Parameters:
AMT_W, 4, width of change amount in units of 10 rupees (max 150 rupees)
CNT_W, 6, width of each inventory counter
INIT_50, 8, 50-rupee coin count loaded on reset/refill
INIT_20, 8, 20-rupee coin count loaded on reset/refill
INIT_10, 8, 10-rupee coin count loaded on reset/refill

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  change request present
req_amount  in  AMT_W  change owed, units of 10 rupees
req_ready  out  1  block can accept a request
coin_valid  out  1  coin eject command valid
coin_type  out  2  coin to eject: 00=10, 01=20, 10=50 (same encoding as payment coin input); 11 never driven
coin_ack  in  1  hopper has ejected the presented coin
done  out  1  one-cycle pulse: full amount paid
fail  out  1  one-cycle pulse: hopper could not cover the remainder
remaining  out  AMT_W  amount still owed, units of 10
cnt50, cnt20, cnt10  out  CNT_W each  current inventory
refill  in  1  reload inventory to INIT_* values

Behaviour:
- Clock and reset: clock clk; reset is synchronous, active-high.
- Reset values:
  - state IDLE; coin_valid=0, coin_type=00, done=0, fail=0, remaining=0.
  - cnt50/20/10 = INIT_50/20/10.
  - req_ready=0 while reset is high.
- States: IDLE, SELECT, ISSUE, DONE, FAIL.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at edge N: latch remaining=req_amount and go to SELECT (cycle N+1).
  - refill in IDLE loads all counters to INIT_*. refill in any other state is ignored.
  - If refill and a request arrive in the same cycle, both take effect.
- SELECT (one cycle, registered decision):
  - remaining==0 -> DONE.
  - else if remaining>=5 and cnt50>0: coin_type=10 -> ISSUE.
  - else if remaining>=2 and cnt20>0: coin_type=01 -> ISSUE.
  - else if remaining>=1 and cnt10>0: coin_type=00 -> ISSUE.
  - else -> FAIL.
- ISSUE:
  - coin_valid=1; coin_type held stable until coin_ack.
  - On coin_ack: subtract the coin value (5/2/1) from remaining, decrement the matching counter, drop coin_valid, go to SELECT.
  - Without ack, stay in ISSUE indefinitely.
  - coin_ack outside ISSUE is ignored.
- Latency: first coin_valid at cycle N+2 after acceptance. With ack held high, each further coin takes 2 cycles.
- DONE: done=1 for one cycle, remaining=0, -> IDLE.
- FAIL:
  - fail=1 for one cycle; remaining holds the unpaid amount until the next request is accepted.
  - -> IDLE.
  - Coins already ejected are not recovered; allocation is greedy with no lookahead.
- req_amount==0: accepted, SELECT -> DONE, done at N+2, no coins.
- Counters never underflow: a denomination with count 0 is never selected. Counters never increment except on refill.
- Reset mid-ISSUE: coin_valid drops on the next edge, request abandoned, inventory restored to INIT_*.
- remaining subtraction never underflows, because a coin is only chosen if its value <= remaining.

Decomposition:
- Shared package vend_pkg holds:
  - coin encodings COIN_10/COIN_20/COIN_50, reused by the payment FSM;
  - coin values in units of 10 (1/2/5);
  - the state encoding constants.
- One natural sub-module: coin_inventory. It holds the three CNT_W counters and provides refill load, decrement-by-type on ack, and nonzero flags to the FSM.

Test Plan:
- Reset, then request amount 3 (30 rupees) with ack held high -> coins 01 then 00; done at cycle N+6; cnt20=7, cnt10=7.
- Request 15 (150 rupees) with INIT defaults -> three coin_type=10 ejections, done pulse, cnt50=5, remaining=0.
- Request 0 -> no coin_valid; done at N+2; req_ready back high at N+3.
- INIT_10=0, request 6 -> coins 10 (50 rupees); SELECT finds no 10s -> fail pulse, remaining=1, cnt50=7.
- Hold coin_ack low 10 cycles during ISSUE -> coin_valid and coin_type stable throughout. Then assert reset mid-ISSUE -> coin_valid=0 next cycle, counters at INIT_*.
- Drain all 20s, then pulse refill in IDLE -> cnt20=8. Pulse refill during ISSUE -> counters unchanged.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared vending definitions: coin encodings, coin values in units of 10 rupees,
// and the change-dispenser state encoding.
package vend_pkg;

  localparam logic [1:0] COIN_10 = 2'b00;
  localparam logic [1:0] COIN_20 = 2'b01;
  localparam logic [1:0] COIN_50 = 2'b10;

  localparam int VAL_10 = 1;
  localparam int VAL_20 = 2;
  localparam int VAL_50 = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAIL   = 3'd4
  } disp_state_e;

  // 2'b11 is never issued, so it maps to zero value.
  function automatic int coin_value(input logic [1:0] coin);
    case (coin)
      COIN_10: coin_value = VAL_10;
      COIN_20: coin_value = VAL_20;
      COIN_50: coin_value = VAL_50;
      default: coin_value = 0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_inventory.sv
// Per-denomination hopper inventory: reload on refill, decrement on an acked
// ejection, and nonzero flags for the coin selector.
module coin_inventory
  import vend_pkg::*;
#(
  parameter int CNT_W   = 6,
  parameter int INIT_50 = 8,
  parameter int INIT_20 = 8,
  parameter int INIT_10 = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             refill_load,
  input  logic             dec_en,
  input  logic [1:0]       dec_type,
  output logic [CNT_W-1:0] cnt50,
  output logic [CNT_W-1:0] cnt20,
  output logic [CNT_W-1:0] cnt10,
  output logic             nz50,
  output logic             nz20,
  output logic             nz10
);

  logic [CNT_W-1:0] cnt50_q, cnt50_d;
  logic [CNT_W-1:0] cnt20_q, cnt20_d;
  logic [CNT_W-1:0] cnt10_q, cnt10_d;

  // Decrement only ever hits a nonzero counter: the selector never picks an empty tube.
  always_comb begin
    cnt50_d = cnt50_q;
    cnt20_d = cnt20_q;
    cnt10_d = cnt10_q;
    if (refill_load) begin
      cnt50_d = CNT_W'(INIT_50);
      cnt20_d = CNT_W'(INIT_20);
      cnt10_d = CNT_W'(INIT_10);
    end else if (dec_en) begin
      case (dec_type)
        COIN_50: cnt50_d = cnt50_q - 1'b1;
        COIN_20: cnt20_d = cnt20_q - 1'b1;
        COIN_10: cnt10_d = cnt10_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt50_q <= CNT_W'(INIT_50);
      cnt20_q <= CNT_W'(INIT_20);
      cnt10_q <= CNT_W'(INIT_10);
    end else begin
      cnt50_q <= cnt50_d;
      cnt20_q <= cnt20_d;
      cnt10_q <= cnt10_d;
    end
  end

  assign cnt50 = cnt50_q;
  assign cnt20 = cnt20_q;
  assign cnt10 = cnt10_q;
  assign nz50  = (cnt50_q != '0);
  assign nz20  = (cnt20_q != '0);
  assign nz10  = (cnt10_q != '0);

endmodule

// File: rtl/change_dispenser.sv
// Coin-return controller: accepts a change amount, pays it out largest coin
// first over a valid/ack handshake, and reports done or shortfall.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W   = 4,
  parameter int CNT_W   = 6,
  parameter int INIT_50 = 8,
  parameter int INIT_20 = 8,
  parameter int INIT_10 = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  output logic             coin_valid,
  output logic [1:0]       coin_type,
  input  logic             coin_ack,
  output logic             done,
  output logic             fail,
  output logic [AMT_W-1:0] remaining,
  output logic [CNT_W-1:0] cnt50,
  output logic [CNT_W-1:0] cnt20,
  output logic [CNT_W-1:0] cnt10,
  input  logic             refill
);

  // Handshakes: a request transfers on a clock edge where req_valid && req_ready;
  // a coin transfers on an edge where coin_valid && coin_ack, and coin_type is
  // held constant from coin_valid rising until that edge.

  disp_state_e      state_q, state_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic             coin_valid_q, coin_valid_d;
  logic [1:0]       coin_type_q, coin_type_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;

  logic dec_en;
  logic refill_load;
  logic nz50, nz20, nz10;

  assign refill_load = refill && (state_q == ST_IDLE);

  coin_inventory #(
    .CNT_W  (CNT_W),
    .INIT_50(INIT_50),
    .INIT_20(INIT_20),
    .INIT_10(INIT_10)
  ) u_inventory (
    .clk        (clk),
    .reset      (reset),
    .refill_load(refill_load),
    .dec_en     (dec_en),
    .dec_type   (coin_type_q),
    .cnt50      (cnt50),
    .cnt20      (cnt20),
    .cnt10      (cnt10),
    .nz50       (nz50),
    .nz20       (nz20),
    .nz10       (nz10)
  );

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    coin_valid_d = coin_valid_q;
    coin_type_d  = coin_type_q;
    done_d       = 1'b0;
    fail_d       = 1'b0;
    dec_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          remaining_d = req_amount;
          state_d     = ST_SELECT;
        end
      end
      // Greedy pick: a coin is chosen only if its value fits, so remaining never underflows.
      ST_SELECT: begin
        if (remaining_q == '0) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (int'(remaining_q) >= VAL_50 && nz50) begin
          coin_type_d  = COIN_50;
          coin_valid_d = 1'b1;
          state_d      = ST_ISSUE;
        end else if (int'(remaining_q) >= VAL_20 && nz20) begin
          coin_type_d  = COIN_20;
          coin_valid_d = 1'b1;
          state_d      = ST_ISSUE;
        end else if (nz10) begin
          coin_type_d  = COIN_10;
          coin_valid_d = 1'b1;
          state_d      = ST_ISSUE;
        end else begin
          fail_d  = 1'b1;
          state_d = ST_FAIL;
        end
      end
      ST_ISSUE: begin
        if (coin_ack) begin
          remaining_d  = remaining_q - AMT_W'(coin_value(coin_type_q));
          dec_en       = 1'b1;
          coin_valid_d = 1'b0;
          state_d      = ST_SELECT;
        end
      end
      ST_DONE: begin
        remaining_d = '0;
        state_d     = ST_IDLE;
      end
      ST_FAIL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      coin_valid_q <= 1'b0;
      coin_type_q  <= COIN_10;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      coin_valid_q <= coin_valid_d;
      coin_type_q  <= coin_type_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE) && !reset;
  assign coin_valid = coin_valid_q;
  assign coin_type  = coin_type_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign remaining  = remaining_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed latency/boundary steps plus randomized
// requests scored against a greedy payout model of the hopper.
module tb_change_dispenser;

  localparam int AMT_W = 4;
  localparam int CNT_W = 6;
  localparam int INIT  = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid, req_valid2;
  logic [AMT_W-1:0] req_amount, req_amount2;
  logic             req_ready, req_ready2;
  logic             coin_valid, coin_valid2;
  logic [1:0]       coin_type, coin_type2;
  logic             coin_ack, coin_ack2;
  logic             done, done2;
  logic             fail, fail2;
  logic [AMT_W-1:0] remaining, remaining2;
  logic [CNT_W-1:0] cnt50, cnt20, cnt10;
  logic [CNT_W-1:0] cnt50_2, cnt20_2, cnt10_2;
  logic             refill, refill2;

  int checks = 0;
  int failures = 0;
  int m50, m20, m10;
  logic [1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  change_dispenser #(.AMT_W(AMT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_amount(req_amount),
    .req_ready(req_ready), .coin_valid(coin_valid), .coin_type(coin_type),
    .coin_ack(coin_ack), .done(done), .fail(fail), .remaining(remaining),
    .cnt50(cnt50), .cnt20(cnt20), .cnt10(cnt10), .refill(refill)
  );

  change_dispenser #(.AMT_W(AMT_W), .CNT_W(CNT_W), .INIT_10(0)) dut_n10 (
    .clk(clk), .reset(reset), .req_valid(req_valid2), .req_amount(req_amount2),
    .req_ready(req_ready2), .coin_valid(coin_valid2), .coin_type(coin_type2),
    .coin_ack(coin_ack2), .done(done2), .fail(fail2), .remaining(remaining2),
    .cnt50(cnt50_2), .cnt20(cnt20_2), .cnt10(cnt10_2), .refill(refill2)
  );

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_cnt50"}, 32'(cnt50), 32'(m50));
    chk({tag, "_cnt20"}, 32'(cnt20), 32'(m20));
    chk({tag, "_cnt10"}, 32'(cnt10), 32'(m10));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk({tag, "_idle_timeout"}, 32'(req_ready), 32'd1);
  endtask

  // Greedy payout model: largest coin that fits and is in stock, until paid or stuck.
  task automatic run_txn(input string tag, input int amt, input bit do_refill, input int max_delay);
    int rem = amt;
    bit finished = 0;
    bit fresh = 1;
    int wait_n = 0;
    if (do_refill) begin m50 = INIT; m20 = INIT; m10 = INIT; end
    exp_q.delete();
    while (rem > 0) begin
      if (rem >= 5 && m50 > 0)      begin exp_q.push_back(2'b10); rem -= 5; m50--; end
      else if (rem >= 2 && m20 > 0) begin exp_q.push_back(2'b01); rem -= 2; m20--; end
      else if (m10 > 0)             begin exp_q.push_back(2'b00); rem -= 1; m10--; end
      else break;
    end
    wait_idle(tag);
    req_valid  = 1'b1;
    req_amount = AMT_W'(amt);
    refill     = do_refill;
    @(negedge clk);
    req_valid = 1'b0;
    refill    = 1'b0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      if (cyc > 0) @(negedge clk);
      coin_ack = 1'b0;
      if (coin_valid) begin
        if (exp_q.size() == 0) begin
          chk({tag, "_unexpected_coin"}, 32'(coin_valid), 32'd0);
          coin_ack = 1'b1;
        end else begin
          chk({tag, fresh ? "_coin_type" : "_coin_hold"}, 32'(coin_type), 32'(exp_q[0]));
          if (fresh) begin
            fresh  = 0;
            wait_n = $urandom_range(0, max_delay);
          end
          if (wait_n == 0) begin
            coin_ack = 1'b1;
            void'(exp_q.pop_front());
            fresh = 1;
          end else begin
            wait_n--;
          end
        end
      end
      if (done || fail) begin
        finished = 1;
        chk({tag, "_done"}, 32'(done), 32'(rem == 0));
        chk({tag, "_fail"}, 32'(fail), 32'(rem != 0));
        chk({tag, "_remaining"}, 32'(remaining), 32'(rem));
        chk({tag, "_coins_left"}, 32'(exp_q.size()), 32'd0);
        chk_counts(tag);
      end
    end
    coin_ack = 1'b0;
    if (!finished) chk({tag, "_end_timeout"}, 32'd0, 32'd1);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int n;
    bit seen;
    int coins2;
    reset = 1'b1; req_valid = 0; req_amount = '0; coin_ack = 0; refill = 0;
    req_valid2 = 0; req_amount2 = '0; coin_ack2 = 0; refill2 = 0;
    m50 = INIT; m20 = INIT; m10 = INIT;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_coin_valid", 32'(coin_valid), 32'd0);
    chk("rst_coin_type", 32'(coin_type), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    chk("rst_remaining", 32'(remaining), 32'd0);
    chk_counts("rst");
    reset = 1'b0;

    // 30 rupees, ack held high: 20 then 10, done seen at N+6.
    @(negedge clk);
    chk("t1_ready", 32'(req_ready), 32'd1);
    req_valid = 1; req_amount = 4'd3; coin_ack = 1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      req_valid = 0;
      chk($sformatf("t1_valid_c%0d", k), 32'(coin_valid), 32'(k == 2 || k == 4));
      if (k == 2) chk("t1_type_c2", 32'(coin_type), 32'd1);
      if (k == 4) chk("t1_type_c4", 32'(coin_type), 32'd0);
      chk($sformatf("t1_done_c%0d", k), 32'(done), 32'(k == 6));
    end
    coin_ack = 0;
    m20 = 7; m10 = 7;
    chk_counts("t1");

    // 150 rupees: three 50s.
    run_txn("t2", 15, 0, 0);
    chk("t2_cnt50_const", 32'(cnt50), 32'd5);

    // Zero amount: no coin, done at N+2, ready again at N+3.
    wait_idle("t3");
    req_valid = 1; req_amount = 4'd0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      req_valid = 0;
      chk($sformatf("t3_valid_c%0d", k), 32'(coin_valid), 32'd0);
      chk($sformatf("t3_done_c%0d", k), 32'(done), 32'(k == 2));
      chk($sformatf("t3_ready_c%0d", k), 32'(req_ready), 32'(k == 3));
    end

    // No 10s stocked: 60 rupees pays one 50 then reports shortfall of 1.
    req_valid2 = 1; req_amount2 = 4'd6; coin_ack2 = 1;
    seen = 0; coins2 = 0;
    for (n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      req_valid2 = 0;
      if (coin_valid2) begin
        coins2++;
        chk("t4_coin_type", 32'(coin_type2), 32'd2);
      end
      if (fail2 || done2) begin
        seen = 1;
        chk("t4_fail", 32'(fail2), 32'd1);
        chk("t4_done", 32'(done2), 32'd0);
        chk("t4_remaining", 32'(remaining2), 32'd1);
        chk("t4_cnt50", 32'(cnt50_2), 32'd7);
        chk("t4_cnt10", 32'(cnt10_2), 32'd0);
        chk("t4_coins", 32'(coins2), 32'd1);
      end
    end
    coin_ack2 = 0;
    if (!seen) chk("t4_timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("t4_remaining_hold", 32'(remaining2), 32'd1);

    // Stalled ack: coin held stable, then reset mid-ISSUE.
    wait_idle("t5");
    req_valid = 1; req_amount = 4'd4;
    @(negedge clk);
    req_valid = 0;
    for (n = 0; n < 10 && !coin_valid; n++) @(negedge clk);
    chk("t5_first_valid", 32'(coin_valid), 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("t5_hold_valid_%0d", k), 32'(coin_valid), 32'd1);
      chk($sformatf("t5_hold_type_%0d", k), 32'(coin_type), 32'd1);
    end
    reset = 1;
    @(negedge clk);
    m50 = INIT; m20 = INIT; m10 = INIT;
    chk("t5_rst_valid", 32'(coin_valid), 32'd0);
    chk("t5_rst_ready", 32'(req_ready), 32'd0);
    chk("t5_rst_remaining", 32'(remaining), 32'd0);
    chk_counts("t5_rst");
    reset = 0;

    // Drain 20s, refill ignored during ISSUE, honoured in IDLE.
    for (int i = 0; i < 8; i++) run_txn($sformatf("t6_drain%0d", i), 2, 0, 1);
    chk("t6_cnt20_empty", 32'(cnt20), 32'd0);
    wait_idle("t6b");
    req_valid = 1; req_amount = 4'd1;
    @(negedge clk);
    req_valid = 0;
    for (n = 0; n < 10 && !coin_valid; n++) @(negedge clk);
    refill = 1;
    @(negedge clk);
    refill = 0;
    chk("t6_issue_valid", 32'(coin_valid), 32'd1);
    chk("t6_issue_cnt20", 32'(cnt20), 32'd0);
    chk("t6_issue_cnt10", 32'(cnt10), 32'd8);
    coin_ack = 1;
    @(negedge clk);
    coin_ack = 0;
    m10--;
    seen = 0;
    for (n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("t6b_done", 32'(seen), 32'd1);
    chk_counts("t6b");
    wait_idle("t6c");
    refill = 1;
    @(negedge clk);
    refill = 0;
    m50 = INIT; m20 = INIT; m10 = INIT;
    chk_counts("t6_refill");

    // Random requests, occasionally with a same-cycle refill.
    for (int i = 0; i < 30; i++)
      run_txn($sformatf("rnd%0d", i), $urandom_range(0, 15), $urandom_range(0, 3) == 0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
